mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port of the five-stage cached core between instruction fetch (IF, read-only refill/fetch) and the memory stage (ME, load/store driven by EX/ME pipeline register outputs). It sequences one transaction at a time through a request/acknowledge handshake with variable memory latency. It also produces the stall signals that freeze the IF and ME pipeline registers.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  core clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (taken branch in ME); cancels the IF transaction only
- if_req  in  1  IF requests a read; held until if_done or flush
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data, valid with if_done
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done (combinational)
- me_req  in  1  ME requests an access; held until me_done
- me_we  in  1  1 = store, 0 = load
- me_wstrb  in  DW/8  byte strobes for stores
- me_addr  in  AW  access address
- me_wdata  in  DW  store data
- me_rdata  out  DW  load data, valid with me_done
- me_done  out  1  one-cycle completion pulse
- me_stall  out  1  me_req & ~me_done (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_wstrb, mem_addr, mem_wdata  out  1/DW/8/AW/DW  registered request fields
- mem_ack  in  1  memory completion, may assert in the first mem_req cycle
- mem_rdata  in  DW  read data, valid with mem_ack

## Operation
- States: IDLE, SERVE_ME, SERVE_IF, DRAIN, RESP.
- IDLE: if me_req, latch the ME fields and go to SERVE_ME. Otherwise, if if_req & ~flush, latch the IF fields (mem_we=0, mem_wstrb=0) and go to SERVE_IF. Otherwise stay.
- SERVE_x: mem_req=1 and fields stay stable. On mem_ack, capture mem_rdata into x_rdata and go to RESP with the done pulse for x armed.
- SERVE_IF with flush and no mem_ack: go to DRAIN. With flush and mem_ack in the same cycle: go to IDLE, no if_done.
- DRAIN: mem_req stays 1 until mem_ack, then go to IDLE. Data is discarded and no if_done is issued.
- RESP: assert x_done for exactly one cycle, go to IDLE. No grant occurs in RESP, so a stale req seen while the pipeline advances is never re-granted.
- flush never affects ME transactions; the older store/load always completes.
- Reset values: state IDLE; mem_req, mem_we, if_done, me_done = 0; mem_wstrb, mem_addr, mem_wdata, if_rdata, me_rdata = 0.
- Reset mid-transaction: mem_req drops the next cycle. The memory shares rst, so no outstanding ack is expected afterwards.
- me_rdata and if_rdata hold their value until the next capture.

## Timing
- A request seen in IDLE at cycle N gives mem_req high from N+1.
- mem_ack at cycle M gives the done pulse at M+1 and IDLE at M+2.
- Minimum turnaround with zero-wait memory: request cycle 0, ack cycle 1, done cycle 2, next grant sampled cycle 3.
- Stalls are combinational from req/done, so a stage advances in its done cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests in IDLE.
  - A last_grant flag is updated at each grant.
  - The requester not served last wins.
  - Reset value of last_grant = IF, so ME wins the first tie.
- Undefined: fixed priority, ME always wins ties.

## Structure
- Package mem_arb_pkg: state enum, the AW/DW defaults, and a grant-source enum (GNT_IF, GNT_ME).
- Sub-module mem_arb_pick: combinational picker taking me_req, if_req & ~flush and last_grant, producing a grant-source enum. It contains the only MEM_ARB_RR_EN-dependent logic.

## Test plan
- Single ME store: me_req=1, me_addr=0x100, me_wdata=0xDEADBEEF, me_wstrb=0xF, zero-wait ack. Required: mem_req at cycle 1, me_done at cycle 2, memory holds 0xDEADBEEF.
- IF read with 3-cycle memory latency at 0x40 returning 0x00000013. Required: if_stall high 4 cycles, then if_done with if_rdata=0x13.
- Simultaneous if_req and me_req. Required: ME served first; IF served second (and in RR builds, IF first on the next tie).
- Flush during SERVE_IF with ack 2 cycles later. Required: DRAIN entered, mem_req held until ack, no if_done, ME request afterwards served normally.
- Flush and mem_ack in the same cycle. Required: IDLE next, no if_done. A flush during SERVE_ME still yields me_done.
- rst asserted in SERVE_ME. Required: next cycle state IDLE, mem_req=0, all outputs zero, no done pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM states and grant-source type for the memory port arbiter
package mem_arb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef enum logic [2:0] {IDLE, SERVE_ME, SERVE_IF, DRAIN, RESP} state_t;
  typedef enum logic {GNT_IF, GNT_ME} gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/ME pipeline handshakes and the unified memory port; slave = arbiter, master = core + memory
interface mem_port_arbiter_if import mem_arb_pkg::*; ();
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          me_req;
  logic          me_we;
  logic [DW/8-1:0] me_wstrb;
  logic [AW-1:0] me_addr;
  logic [DW-1:0] me_wdata;
  logic [DW-1:0] me_rdata;
  logic          me_done;
  logic          me_stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  flush, if_req, if_addr, me_req, me_we, me_wstrb, me_addr, me_wdata, mem_ack, mem_rdata,
    output if_rdata, if_done, if_stall, me_rdata, me_done, me_stall, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
  modport master (
    output flush, if_req, if_addr, me_req, me_we, me_wstrb, me_addr, me_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_done, if_stall, me_rdata, me_done, me_stall, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses IF or ME on a grant; MEM_ARB_RR_EN gives round-robin ties, otherwise ME has fixed priority
module mem_arb_pick import mem_arb_pkg::*; (
  input  logic me_req,
  input  logic if_req,
  input  gnt_t last_grant,
  output gnt_t gnt
);
`ifdef MEM_ARB_RR_EN
  assign gnt = (me_req && !(if_req && last_grant == GNT_ME)) ? GNT_ME : GNT_IF;
`else
  logic unused_pick;
  assign unused_pick = ^{if_req, last_grant};
  assign gnt = me_req ? GNT_ME : GNT_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences IF fetches and ME loads/stores over one memory port (tie policy via MEM_ARB_RR_EN)
module mem_port_arbiter import mem_arb_pkg::*; (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  state_t state, state_nx;
  gnt_t gnt, last_grant, src;
  logic if_v, grant, is_me;
  assign if_v  = bus.if_req & ~bus.flush;
  assign grant = (state == IDLE) && (bus.me_req || if_v);
  assign is_me = gnt == GNT_ME;
  mem_arb_pick u_pick (
    .me_req    (bus.me_req),
    .if_req    (if_v),
    .last_grant(last_grant),
    .gnt       (gnt)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = grant ? (is_me ? SERVE_ME : SERVE_IF) : IDLE;
      SERVE_ME: state_nx = bus.mem_ack ? RESP : SERVE_ME;
      SERVE_IF: state_nx = bus.mem_ack ? (bus.flush ? IDLE : RESP) : (bus.flush ? DRAIN : SERVE_IF);
      DRAIN:    state_nx = bus.mem_ack ? IDLE : DRAIN;
      default:  state_nx = IDLE;
    endcase
  end
  assign bus.mem_req  = (state == SERVE_ME) || (state == SERVE_IF) || (state == DRAIN);
  assign bus.me_done  = (state == RESP) && (src == GNT_ME);
  assign bus.if_done  = (state == RESP) && (src == GNT_IF);
  assign bus.me_stall = bus.me_req & ~bus.me_done;
  assign bus.if_stall = bus.if_req & ~bus.if_done;
  // Request fields are latched only at grant so they stay stable for the whole access.
  always_ff @(posedge clk)
    if (rst) begin
      last_grant    <= GNT_IF;
      src           <= GNT_IF;
      bus.mem_we    <= 1'b0;
      bus.mem_wstrb <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.me_rdata  <= '0;
    end else begin
      if (grant) begin
        last_grant    <= gnt;
        src           <= gnt;
        bus.mem_we    <= is_me & bus.me_we;
        bus.mem_wstrb <= is_me ? bus.me_wstrb : '0;
        bus.mem_addr  <= is_me ? bus.me_addr : bus.if_addr;
        bus.mem_wdata <= is_me ? bus.me_wdata : '0;
      end
      if (state == SERVE_ME && bus.mem_ack) bus.me_rdata <= bus.mem_rdata;
      if (state == SERVE_IF && bus.mem_ack && !bus.flush) bus.if_rdata <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a word-level memory/ordering reference
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic do_init = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int fix_lat = 0;
  int rnd_lat = 0;
  int cnt = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // memory: ack after a per-transaction latency, byte-strobed writes at ack
  assign bus.mem_ack   = bus.mem_req && (cnt == ((fix_lat >= 0) ? fix_lat : rnd_lat));
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (rst || !bus.mem_req || bus.mem_ack) begin
      cnt <= 0;
      rnd_lat <= int'($urandom_range(0, 3));
    end else cnt <= cnt + 1;
    if (do_init) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (bus.mem_req && bus.mem_ack && bus.mem_we)
      mem[bus.mem_addr[9:2]] <= merge(mem[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_wstrb);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_me(logic req, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    bus.me_req = req; bus.me_we = we; bus.me_addr = addr; bus.me_wdata = wdata; bus.me_wstrb = wstrb;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    do_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_init = 1'b0;
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.if_done, bus.me_done} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_req, bus.mem_we, bus.if_done, bus.me_done});
    end
    n_cmp++;
    if ({bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_me_store;
    fix_lat = 0;
    set_me(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    n_cmp++;
    if (bus.me_stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_bad++; $display("FAIL store_c0: got stall=%b req=%b want 1 0", bus.me_stall, bus.mem_req);
    end
    tick;
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_ack, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {3'b111, 32'h100, 32'hDEADBEEF, 4'hF}) begin
      n_bad++; $display("FAIL store_c1: got %h want %h", {bus.mem_req, bus.mem_we, bus.mem_ack, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {3'b111, 32'h100, 32'hDEADBEEF, 4'hF});
    end
    tick;
    n_cmp++;
    if ({bus.me_done, bus.me_stall, bus.mem_req} !== 3'b100) begin
      n_bad++; $display("FAIL store_c2: got done/stall/req=%b want 100", {bus.me_done, bus.me_stall, bus.mem_req});
    end
    set_me(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ref_mem[64] = 32'hDEADBEEF;
    tick;
    n_cmp++;
    if (bus.me_done !== 1'b0 || mem[64] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL store_c3: got done=%b mem=%h want 0 deadbeef", bus.me_done, mem[64]);
    end
  endtask

  task automatic test_if_read;
    int stall_n = 0;
    logic got = 1'b0;
    fix_lat = 2;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus.if_done) got = 1'b1;
      else begin
        stall_n += int'(bus.if_stall);
        tick;
      end
    end
    n_cmp++;
    if (!got || stall_n != 4) begin
      n_bad++; $display("FAIL if_stall_len: got done=%b stalls=%0d want 1 4", got, stall_n);
    end
    n_cmp++;
    if (bus.if_rdata !== 32'h13) begin
      n_bad++; $display("FAIL if_rdata: got %h want 00000013", bus.if_rdata);
    end
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_tie;
    logic [23:0] ord = '0;
    int k = 0;
    int me_left = 2;
    logic [23:0] exp_ord;
`ifdef MEM_ARB_RR_EN
    exp_ord = "MIM";
`else
    exp_ord = "MMI";
`endif
    fix_lat = 0;
    set_me(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h44;
    for (int c = 0; c < 40 && k < 3; c++) begin
      #1;
      if (bus.me_done) begin
        ord = {ord[15:0], 8'("M")}; k++;
        n_cmp++;
        if (bus.me_rdata !== ref_mem[bus.me_addr[9:2]]) begin
          n_bad++; $display("FAIL tie_me_data: got %h want %h", bus.me_rdata, ref_mem[bus.me_addr[9:2]]);
        end
        me_left--;
        if (me_left > 0) bus.me_addr = 32'h204;
        else bus.me_req = 1'b0;
      end
      if (bus.if_done) begin
        ord = {ord[15:0], 8'("I")}; k++;
        n_cmp++;
        if (bus.if_rdata !== ref_mem[17]) begin
          n_bad++; $display("FAIL tie_if_data: got %h want %h", bus.if_rdata, ref_mem[17]);
        end
        bus.if_req = 1'b0;
      end
      tick;
    end
    n_cmp++;
    if (ord !== exp_ord) begin
      n_bad++; $display("FAIL tie_order: got %s want %s", ord, exp_ord);
    end
    bus.me_req = 1'b0;
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_flush_drain;
    int done_c = -1;
    logic bad_if = 1'b0;
    fix_lat = 2;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h48;
    tick;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    bus.if_req = 1'b0;
    set_me(1'b1, 1'b0, 32'h208, 32'h0, 4'h0);
    for (int c = 2; c < 14; c++) begin
      #1;
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_ack !== (c == 3)) begin
          n_bad++; $display("FAIL drain_hold_c%0d: got req=%b ack=%b want 1 %b", c, bus.mem_req, bus.mem_ack, c == 3);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
          n_bad++; $display("FAIL drain_idle: got mem_req=%b want 0", bus.mem_req);
        end
      end
      if (bus.if_done) bad_if = 1'b1;
      if (bus.me_done && done_c < 0) begin
        done_c = c;
        n_cmp++;
        if (bus.me_rdata !== ref_mem[130]) begin
          n_bad++; $display("FAIL drain_me_data: got %h want %h", bus.me_rdata, ref_mem[130]);
        end
        bus.me_req = 1'b0;
      end
      tick;
    end
    n_cmp++;
    if (bad_if || done_c != 8) begin
      n_bad++; $display("FAIL drain_seq: got if_done_seen=%b me_done_cycle=%0d want 0 8", bad_if, done_c);
    end
  endtask

  task automatic test_flush_ack;
    logic got = 1'b0;
    fix_lat = 1;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4C;
    tick;
    tick;
    bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_ack !== 1'b1) begin
      n_bad++; $display("FAIL fa_ack: got mem_ack=%b want 1", bus.mem_ack);
    end
    tick;
    n_cmp++;
    if ({bus.mem_req, bus.if_done} !== 2'b00) begin
      n_bad++; $display("FAIL fa_idle: got req/if_done=%b want 00", {bus.mem_req, bus.if_done});
    end
    bus.flush = 1'b0;
    bus.if_req = 1'b0;
    tick;
    set_me(1'b1, 1'b0, 32'h20C, 32'h0, 4'h0);
    tick;
    bus.flush = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (bus.me_done) got = 1'b1;
      else tick;
    end
    n_cmp++;
    if (!got || bus.me_rdata !== ref_mem[131]) begin
      n_bad++; $display("FAIL flush_me: got done=%b data=%h want 1 %h", got, bus.me_rdata, ref_mem[131]);
    end
    bus.flush = 1'b0;
    bus.me_req = 1'b0;
    tick;
  endtask

  task automatic test_rst_mid;
    logic seen = 1'b0;
    fix_lat = 3;
    set_me(1'b1, 1'b1, 32'h300, 32'h55, 4'hF);
    tick;
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre: got mem_req=%b want 1", bus.mem_req);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.me_req = 1'b0;
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.if_done, bus.me_done} !== 4'b0 ||
        {bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata} !== '0) begin
      n_bad++; $display("FAIL rst_mid: got ctrl=%b data=%h want 0 0", {bus.mem_req, bus.mem_we, bus.if_done, bus.me_done},
                        {bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata});
    end
    repeat (5) begin
      tick;
      if (bus.me_done || bus.mem_req) seen = 1'b1;
    end
    n_cmp++;
    if (seen || mem[192] !== ref_mem[192]) begin
      n_bad++; $display("FAIL rst_after: got activity=%b mem=%h want 0 %h", seen, mem[192], ref_mem[192]);
    end
  endtask

  task automatic test_random;
    logic me_busy = 1'b0, if_busy = 1'b0, ack_prev = 1'b0, flush_prev = 1'b0;
    logic md, id;
    int me_wait = 0, me_n = 0, if_n = 0;
    fix_lat = -1;
    for (int c = 0; c < 400; c++) begin
      #1;
      md = bus.me_done;
      id = bus.if_done;
      if (md || id) begin
        n_cmp++;
        if (!ack_prev || (md && id) || bus.mem_req) begin
          n_bad++; $display("FAIL rnd_done_rule: got ack_prev=%b me=%b if=%b req=%b want 1 exclusive 0", ack_prev, md, id, bus.mem_req);
        end
      end
      if (bus.mem_ack && bus.mem_we) begin
        n_cmp++;
        if (!(me_busy && bus.me_we) || {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {bus.me_addr, bus.me_wdata, bus.me_wstrb}) begin
          n_bad++; $display("FAIL rnd_store_fields: got %h want %h", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {bus.me_addr, bus.me_wdata, bus.me_wstrb});
        end
      end
      if (md) begin
        if (bus.me_we) ref_mem[bus.me_addr[9:2]] = merge(ref_mem[bus.me_addr[9:2]], bus.me_wdata, bus.me_wstrb);
        else begin
          n_cmp++;
          if (bus.me_rdata !== ref_mem[bus.me_addr[9:2]]) begin
            n_bad++; $display("FAIL rnd_me_load: got %h want %h", bus.me_rdata, ref_mem[bus.me_addr[9:2]]);
          end
        end
        me_busy = 1'b0; me_n++; me_wait = 0;
      end
      if (id) begin
        n_cmp++;
        if (flush_prev || !if_busy || bus.if_rdata !== ref_mem[bus.if_addr[9:2]]) begin
          n_bad++; $display("FAIL rnd_if: got flushed=%b busy=%b data=%h want 0 1 %h", flush_prev, if_busy, bus.if_rdata, ref_mem[bus.if_addr[9:2]]);
        end
        if_busy = 1'b0; if_n++;
      end
      if (me_busy && ++me_wait > 60) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_timeout: got no me_done after %0d cycles want done", me_wait);
        break;
      end
      ack_prev = bus.mem_ack;
      bus.flush = 1'b0;
      if (if_busy && !id && $urandom_range(0, 15) == 0) begin
        bus.flush = 1'b1; bus.if_req = 1'b0; if_busy = 1'b0;
      end else if (!if_busy && $urandom_range(0, 1) == 1) begin
        bus.if_req = 1'b1; bus.if_addr = 32'($urandom_range(0, 255)) << 2; if_busy = 1'b1;
      end else if (!if_busy) bus.if_req = 1'b0;
      if (!me_busy && $urandom_range(0, 2) == 0) begin
        set_me(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom_range(0, 15)));
        me_busy = 1'b1;
      end else if (!me_busy) bus.me_req = 1'b0;
      flush_prev = bus.flush;
      tick;
    end
    n_cmp++;
    if (me_n < 10 || if_n < 10) begin
      n_bad++; $display("FAIL rnd_progress: got me=%0d if=%0d want >=10 each", me_n, if_n);
    end
    bus.flush = 1'b0; bus.if_req = 1'b0; bus.me_req = 1'b0;
    repeat (8) tick;
  endtask

  initial begin
    bus.flush = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
    set_me(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    test_reset;
    test_me_store;
    test_if_read;
    test_tie;
    test_flush_drain;
    test_flush_ack;
    test_rst_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
